// File: rtl/bitcnt_unit.sv
// Iterative clz/ctz/cpop unit that examines BPC operand bits per cycle.
// Latency: result_valid rises exactly XLEN/BPC cycles after the accept edge.
// Backpressure: the result is held in DONE until result_ready; in_ready is high only in IDLE.
module bitcnt_unit #(
  parameter int XLEN = 32,
  parameter int BPC  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_alu_ctrl,
  input  logic [1:0]      in_op_sel,
  input  logic [XLEN-1:0] in_src_a,
  input  logic            flush,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int ITER = XLEN / BPC;
  localparam int AW   = $clog2(XLEN + 1);
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [3:0] BITCNT_CTRL = 4'b1111;
  localparam logic [1:0] OP_CLZ      = 2'b00;
  localparam logic [1:0] OP_CTZ      = 2'b01;
  localparam logic [1:0] OP_CPOP     = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [1:0]      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            found_q, found_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            in_ready_q, in_ready_d;
  logic            result_valid_q, result_valid_d;
  logic            busy_q, busy_d;

  logic [AW-1:0]   slice_acc;
  logic            slice_found;
  logic [XLEN-1:0] opnd_shift;

  // Evaluate the current BPC-bit slice. The operand register is shifted so the
  // slice to examine always sits at the top (clz) or bottom (ctz/cpop).
  always_comb begin
    slice_acc   = acc_q;
    slice_found = found_q;
    for (int i = 0; i < BPC; i++) begin
      case (op_q)
        OP_CLZ: begin
          if (!slice_found) begin
            if (opnd_q[XLEN-1-i]) slice_found = 1'b1;
            else                  slice_acc   = slice_acc + AW'(1);
          end
        end
        OP_CTZ: begin
          if (!slice_found) begin
            if (opnd_q[i]) slice_found = 1'b1;
            else           slice_acc   = slice_acc + AW'(1);
          end
        end
        OP_CPOP: slice_acc = slice_acc + AW'(opnd_q[i]);
        default: ; // reserved encoding leaves the count at zero
      endcase
    end
    if (op_q == OP_CLZ) opnd_shift = opnd_q << BPC;
    else                opnd_shift = opnd_q >> BPC;
  end

  // Next-state and next-output logic; flush overrides everything, outputs are
  // derived from the next state so they come straight out of flops.
  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    found_d  = found_q;
    result_d = '0;

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      found_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && (in_alu_ctrl == BITCNT_CTRL)) begin
            state_d = RUN;
            opnd_d  = in_src_a;
            op_d    = in_op_sel;
            cnt_d   = '0;
            acc_d   = '0;
            found_d = 1'b0;
          end
        end
        RUN: begin
          acc_d   = slice_acc;
          found_d = slice_found;
          opnd_d  = opnd_shift;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(ITER - 1)) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = XLEN'(slice_acc);
          end
        end
        DONE: begin
          result_d = result_q;
          if (result_ready) begin
            state_d  = IDLE;
            result_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    in_ready_d     = (state_d == IDLE);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  // State, datapath and registered outputs; reset returns to an idle, ready unit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      opnd_q         <= '0;
      op_q           <= '0;
      cnt_q          <= '0;
      acc_q          <= '0;
      found_q        <= 1'b0;
      result_q       <= '0;
      in_ready_q     <= 1'b1;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      opnd_q         <= opnd_d;
      op_q           <= op_d;
      cnt_q          <= cnt_d;
      acc_q          <= acc_d;
      found_q        <= found_d;
      result_q       <= result_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign result_valid = result_valid_q;
  assign result       = result_q;
  assign busy         = busy_q;

endmodule

// File: doc/bitcnt_unit.md
BITCNT_UNIT -- requirements
Module: bitcnt_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width.
REQ-002 SHALL have parameter BPC, default 4, bits examined per cycle; XLEN divisible by BPC; ITER = XLEN/BPC.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  request present from decode/issue.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port in_alu_ctrl  input  4  ALUControl from the ALU decoder; only 4'b1111 (clz/ctz/cpop group) is a request.
REQ-008 SHALL have port in_op_sel  input  2  rs2 field low bits: 00 clz, 01 ctz, 10 cpop, 11 reserved.
REQ-009 SHALL have port in_src_a  input  XLEN  operand rs1.
REQ-010 SHALL have port flush  input  1  synchronous kill of in-flight op.
REQ-011 SHALL have port result_valid  output  1  result available.
REQ-012 SHALL have port result_ready  input  1  consumer takes result.
REQ-013 SHALL have port result  output  XLEN  count, zero-extended.
REQ-014 SHALL have port busy  output  1  high in RUN or DONE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; result_valid = 1 only in DONE.
REQ-017 Accept SHALL occur on an edge where state=IDLE, in_valid=1, in_alu_ctrl=4'b1111, flush=0: capture in_src_a, in_op_sel; clear accumulator and iteration counter; go RUN.
REQ-018 in_valid with in_alu_ctrl != 4'b1111 SHALL be ignored; state stays IDLE.
REQ-019 Each RUN edge SHALL process one BPC-bit slice (clz: MSB slice first; ctz, cpop: LSB slice first) and increment counter; on the edge with counter = ITER-1, go DONE.
REQ-020 Latency SHALL be fixed: result_valid rises exactly ITER cycles (8 at defaults) after the accept edge, independent of operand value.
REQ-021 clz SHALL count leading zeros, ctz trailing zeros; both stop accumulating after the first 1 found; all-zero operand gives XLEN.
REQ-022 cpop SHALL count set bits; range 0..XLEN.
REQ-023 Reserved op_sel 11 SHALL give result 0 with the same latency.
REQ-024 Accumulator width SHALL be clog2(XLEN+1) bits; result upper bits zero.
REQ-025 In DONE, result and result_valid SHALL hold stable until result_ready=1; that edge returns to IDLE (one IDLE cycle before next accept).
REQ-026 Input changes after accept SHALL not affect the result.
REQ-027 flush=1 SHALL take priority over every other event: next state IDLE, pending result dropped, no accept that edge.
REQ-028 result SHALL read 0 in IDLE and RUN.

Reset
REQ-029 rst_n=0 SHALL immediately, without clock, force state IDLE, counter 0, accumulator 0, result 0, result_valid 0, busy 0, in_ready 1.
REQ-030 Reset asserted mid-RUN or in DONE SHALL discard the op; no result_valid after release until a new accept.
REQ-031 First accept SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-032 clz, src 0x0001_0000, result_ready=1 -> result_valid exactly 8 cycles after accept, result 15, IDLE next cycle.
REQ-033 clz and ctz of 0x0000_0000 -> 32; ctz 0x8000_0000 -> 31; clz 0xFFFF_FFFF -> 0.
REQ-034 cpop 0xF0F0_00FF -> 16; cpop 0xFFFF_FFFF -> 32; op_sel 11 -> 0.
REQ-035 Backpressure: result_ready=0 for 5 cycles in DONE -> result_valid, result stable, in_ready 0; new in_valid not accepted; take on 6th cycle.
REQ-036 flush on 4th RUN cycle -> IDLE next edge, result_valid never rises; rst_n pulsed low mid-RUN -> outputs at reset values immediately.
REQ-037 in_valid=1 with in_alu_ctrl=4'b0000 for 3 cycles -> no accept, busy 0; changing in_src_a after accept does not alter result.
